// File: rtl/operand_sel_sync.sv
// Operand selector with synchronised switch path and optional button-confirmed switch read.
// Define OPSEL_HANDSHAKE_EN to build the debouncer/handshake FSM; otherwise switches are read live.
module operand_sel_sync #(
    parameter int unsigned N          = 8,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] sw_in,
    input  logic [N-1:0] imm_pm,
    input  logic         sel_ext,
    input  logic         sel_imm,
    input  logic         sw_req,
    input  logic         btn_in,
    output logic [N-1:0] operand,
    output logic         stall,
    output logic         sw_valid
);

    logic [N-1:0] sw_meta;
    logic [N-1:0] sw_sync;
    logic [N-1:0] sel_val;
    logic         capture;
    logic         hold;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_comb begin
        sel_val = rs_data;
        if (sel_ext) sel_val = sel_imm ? imm_pm : sw_sync;
    end

`ifdef OPSEL_HANDSHAKE_EN
    typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease} state_e;

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    state_e          state;
    logic            btn_meta;
    logic            btn_sync;
    logic            btn_db;
    logic            btn_db_prev;
    logic [CntW-1:0] deb_cnt;
    logic            swr;
    logic            btn_rise;

    assign swr      = sw_req & sel_ext & ~sel_imm;
    assign btn_rise = btn_db & ~btn_db_prev;

    // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            btn_meta    <= btn_in;
            btn_sync    <= btn_meta;
            btn_db_prev <= btn_db;
            if (btn_sync == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CntMax) begin
                btn_db  <= btn_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= StIdle;
            sw_valid <= 1'b0;
        end else begin
            sw_valid <= 1'b0;
            case (state)
                StIdle: if (swr) state <= StWaitPress;
                StWaitPress: begin
                    if (btn_rise) begin
                        state    <= StWaitRelease;
                        sw_valid <= 1'b1;
                    end
                end
                StWaitRelease: if (!btn_db) state <= swr ? StWaitPress : StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Decoded from registered state; swr only adds a request qualifier, never btn_in.
    assign stall   = (state == StWaitPress) | ((state == StWaitRelease) & swr);
    assign capture = (state == StWaitPress) & btn_rise;
    assign hold    = stall;
`else
    logic unused_inputs;
    assign unused_inputs = btn_in ^ sw_req;
    assign stall         = 1'b0;
    assign sw_valid      = 1'b0;
    assign capture       = 1'b0;
    assign hold          = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            operand <= '0;
        end else if (capture) begin
            operand <= sw_sync;
        end else if (!hold) begin
            operand <= sel_val;
        end
    end

endmodule

// File: tb/tb_operand_sel_sync.sv
// Scoreboard bench for operand_sel_sync; handshake checks compile in with OPSEL_HANDSHAKE_EN.
module tb_operand_sel_sync;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       n_reset;
    logic [7:0] rs_data, sw_in, imm_pm;
    logic       sel_ext, sel_imm, sw_req, btn_in;
    logic [7:0] operand;
    logic       stall, sw_valid;

    int         n_total = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m1 = 8'h00;
    logic [7:0] m2 = 8'h00;

    operand_sel_sync #(.N(8), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .rs_data  (rs_data),
        .sw_in    (sw_in),
        .imm_pm   (imm_pm),
        .sel_ext  (sel_ext),
        .sel_imm  (sel_imm),
        .sw_req   (sw_req),
        .btn_in   (btn_in),
        .operand  (operand),
        .stall    (stall),
        .sw_valid (sw_valid)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push the value operand must hold after the next edge; m1/m2 model the two sync flops.
    task automatic drive(input logic [7:0] rs, input logic [7:0] imm, input logic [7:0] sw,
                         input logic ext, input logic isel);
        logic [7:0] e;
        rs_data = rs;
        imm_pm  = imm;
        sw_in   = sw;
        sel_ext = ext;
        sel_imm = isel;
        e = !ext ? rs : (isel ? imm : m2);
        exp_q.push_back(e);
        m2 = m1;
        m1 = sw;
    endtask

    task automatic settle();
        logic [7:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("operand", operand, e);
        end
        check_val("stall_idle", stall, 0);
        check_val("sw_valid_idle", sw_valid, 0);
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sw_valid) pulses++;
        end
    endtask

    initial begin
        int p, p2, lat;
        n_reset = 1'b0;
        rs_data = 8'h55; sw_in = 8'h00; imm_pm = 8'h00;
        sel_ext = 1'b0; sel_imm = 1'b0; sw_req = 1'b0; btn_in = 1'b0;

        // Reset with clock stopped, then with clock running.
        #20;
        check_val("rst_operand_noclk", operand, 8'h00);
        check_val("rst_stall_noclk", stall, 0);
        check_val("rst_valid_noclk", sw_valid, 0);
        clk_en = 1'b1;
        #23;
        check_val("rst_operand_clk", operand, 8'h00);
        check_val("rst_stall_clk", stall, 0);
        @(negedge clk);
        n_reset = 1'b1;

        drive(8'hFD, 8'h00, 8'h00, 1'b0, 1'b0); settle();
        drive(8'h00, 8'h12, 8'h00, 1'b1, 1'b1); settle();
        for (int i = 0; i < 4; i++) begin
            drive(8'h00, 8'h00, 8'h3C, 1'b1, 1'b0); settle();
        end
        for (int i = 0; i < 40; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            settle();
        end

`ifdef OPSEL_HANDSHAKE_EN
        sel_ext = 1'b1; sel_imm = 1'b0; sw_in = 8'hA5;
        run(3, p);
        sw_req = 1'b1;
        @(negedge clk);
        check_val("req_stall", stall, 1);
        sw_req = 1'b0;
        @(negedge clk);
        check_val("wait_stall", stall, 1);
        btn_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_val("press_early_valid", sw_valid, 0);
            check_val("press_early_stall", stall, 1);
        end
        @(negedge clk);
        check_val("press_valid", sw_valid, 1);
        check_val("press_operand", operand, 8'hA5);
        check_val("press_stall", stall, 0);
        run(6, p);
        check_val("held_no_repulse", p, 0);
        sw_req = 1'b1;
        @(negedge clk);
        check_val("held_req_stall", stall, 1);
        run(4, p);
        check_val("held_req_no_valid", p, 0);
        sw_req = 1'b0; btn_in = 1'b0;
        run(10, p);
        check_val("release_idle_stall", stall, 0);

        // Short bounce must not capture; stalled operand must hold despite new switches.
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0; sw_in = 8'h77; btn_in = 1'b1;
        run(3, p);
        btn_in = 1'b0;
        run(10, p2);
        check_val("bounce_no_valid", p + p2, 0);
        check_val("bounce_stall", stall, 1);
        check_val("bounce_hold", operand, 8'hA5);
        btn_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (sw_valid) lat = i;
        end
        check_val("press2_latency", lat, 7);
        check_val("press2_operand", operand, 8'h77);
        btn_in = 1'b0;
        run(10, p);
        check_val("press2_idle", stall, 0);

        // Reset mid-handshake abandons the request.
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        check_val("rst_mid_stall_pre", stall, 1);
        #2 n_reset = 1'b0;
        #1;
        check_val("rst_mid_stall", stall, 0);
        check_val("rst_mid_operand", operand, 8'h00);
        @(negedge clk);
        n_reset = 1'b1;
        btn_in = 1'b1;
        run(12, p);
        check_val("rst_mid_no_valid", p, 0);
        check_val("rst_mid_stall_after", stall, 0);
        btn_in = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
